ram_responder: RTL

- Behavioural and synthesizable RAM endpoint on the ram side of the ram* bus. Serves the ramREN/ramWEN/ramaddr/ramstore requests issued by the memory controller.
- Reports progress on ramstate as FREE, BUSY, ACCESS or ERROR, with a programmable access latency.
- Used as the memory model in system benches and as the on-chip RAM in FPGA builds.

---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/ram_word_array.sv | 28 ++
 rtl/ram_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory-bus types and RAM endpoint defaults
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Progress reported by a RAM endpoint on the ram* bus
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT   = 2;
    localparam int RAM_DEPTH_DEFAULT = 1024;

    // Operation captured when a request is latched
    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } ram_op_t;

    // Responder FSM: waiting for a request, or counting down a latched one
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ram_fsm_t;

endpackage

// File: rtl/ram_word_array.sv
// rtl/ram_word_array.sv - DEPTH x 32 word storage, synchronous write, asynchronous read
module ram_word_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_widx,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_ridx,
    output word_t         o_rdata
);

    // Contents are deliberately not reset so a reset never disturbs stored data
    word_t r_mem [DEPTH];

    // Commit a write on the closing edge of the write's ACCESS cycle
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - ram* bus RAM endpoint with programmable access latency
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = RAM_LAT_DEFAULT,
    parameter int DEPTH = RAM_DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_ram_ren,
    input  logic      i_ram_wen,
    input  word_t     i_ram_addr,
    input  word_t     i_ram_store,
    output word_t     o_ram_load,
    output ramstate_t o_ram_state
);

    localparam word_t      LP_ADDR_LIMIT = word_t'(DEPTH * 4);
    localparam logic [7:0] LP_LAT        = 8'(LAT);

    ram_fsm_t      r_state;
    logic [7:0]    r_cnt;
    logic [AW-1:0] r_lat_addr;
    ram_op_t       r_lat_op;
    word_t         r_lat_data;

    ram_fsm_t      w_state_nxt;
    logic [7:0]    w_cnt_nxt;
    logic [AW-1:0] w_lat_addr_nxt;
    ram_op_t       w_lat_op_nxt;
    word_t         w_lat_data_nxt;

    logic          w_req;
    logic          w_bad;
    ram_op_t       w_op;
    logic [AW-1:0] w_idx;
    logic          w_match;
    logic          w_access;
    logic          w_we;
    word_t         w_rdata;

    assign w_req = i_ram_ren | i_ram_wen;
    assign w_bad = (i_ram_ren & i_ram_wen)
                 | (i_ram_addr[1:0] != 2'b00)
                 | (i_ram_addr >= LP_ADDR_LIMIT);
    assign w_op  = i_ram_wen ? OP_WRITE : OP_READ;
    assign w_idx = i_ram_addr[AW+1:2];

    // A good request has no address bits above the index, so comparing the index is enough
    assign w_match = (w_op == r_lat_op) && (w_idx == r_lat_addr)
                   && ((r_lat_op == OP_READ) || (i_ram_store == r_lat_data));

    // State, countdown and request latch
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_lat_addr <= '0;
            r_lat_op   <= OP_READ;
            r_lat_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lat_addr <= w_lat_addr_nxt;
            r_lat_op   <= w_lat_op_nxt;
            r_lat_data <= w_lat_data_nxt;
        end
    end

    // Next state, latch updates and the bus-facing status
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_lat_addr_nxt = r_lat_addr;
        w_lat_op_nxt   = r_lat_op;
        w_lat_data_nxt = r_lat_data;
        w_access       = 1'b0;
        o_ram_state    = FREE;

        case (r_state)
            ST_IDLE: begin
                if (w_req && !w_bad) begin
                    w_lat_addr_nxt = w_idx;
                    w_lat_op_nxt   = w_op;
                    w_lat_data_nxt = i_ram_store;
                    w_cnt_nxt      = LP_LAT;
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_req || w_bad) begin
                    // Controller withdrew or broke the request: abandon it, nothing is written
                    w_state_nxt = ST_IDLE;
                end else if (!w_match) begin
                    // Controller switched requests mid-wait: the latency restarts from the new one
                    w_lat_addr_nxt = w_idx;
                    w_lat_op_nxt   = w_op;
                    w_lat_data_nxt = i_ram_store;
                    w_cnt_nxt      = LP_LAT;
                end else if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (!i_rst_n) begin
            o_ram_state = FREE;
        end else if (w_req && w_bad) begin
            o_ram_state = ERROR;
        end else if (!w_req) begin
            o_ram_state = FREE;
        end else if (w_access) begin
            o_ram_state = ACCESS;
        end else begin
            o_ram_state = BUSY;
        end
    end

    assign w_we       = w_access && (r_lat_op == OP_WRITE);
    assign o_ram_load = (w_access && (r_lat_op == OP_READ)) ? w_rdata : '0;

    ram_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_widx  (r_lat_addr),
        .i_wdata (r_lat_data),
        .i_ridx  (r_lat_addr),
        .o_rdata (w_rdata)
    );

endmodule
